// File: rtl/proc_pkg.sv
// Shared definitions for the channel-processing pipeline: default geometry,
// packer state encoding and a counter-width helper.
package proc_pkg;

  localparam int unsigned CH_DEF   = 22;
  localparam int unsigned SW_DEF   = 16;
  localparam int unsigned CNT_DEF  = 1000;
  localparam int unsigned LEAD_DEF = 3;
  localparam int unsigned FRAME_W  = CH_DEF * SW_DEF;

  typedef enum logic [2:0] {
    IDLE,
    START,
    PRIME,
    FILL,
    WAIT_DONE
  } packer_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_frame_packer.sv
// Packs CH serial samples per frame for the processing block, opens each batch
// of CNT frames with a lead-timed start pulse and waits for the consumer's done.
module sample_frame_packer
  import proc_pkg::*;
#(
  parameter int unsigned CNT  = CNT_DEF,
  parameter int unsigned CH   = CH_DEF,
  parameter int unsigned SW   = SW_DEF,
  parameter int unsigned LEAD = LEAD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [SW-1:0]    s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_last,
  input  logic             batch_done,
  output logic [CH*SW-1:0] data_in,
  output logic             data_in_valid,
  output logic             start_flag,
  output logic             busy,
  output logic             align_err
);

  localparam int unsigned DW  = CH * SW;
  localparam int unsigned CW  = cnt_w(CH);
  localparam int unsigned FCW = cnt_w(CNT);
  localparam int unsigned LW  = cnt_w(LEAD + 1);

  packer_state_e  state_q, state_d;
  logic [CW-1:0]  ch_cnt_q, ch_cnt_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [LW-1:0]  lead_q, lead_d;
  logic [DW-1:0]  sh_q, sh_d;
  logic [DW-1:0]  data_q, data_d;
  logic           dv_q, dv_d;
  logic           err_q, err_d;
  logic           ch_last;
  logic           frame_last;

  assign ch_last    = (ch_cnt_q == CW'(CH - 1));
  assign frame_last = (frame_cnt_q == FCW'(CNT - 1));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_cnt_q    <= '0;
      frame_cnt_q <= '0;
      lead_q      <= '0;
      sh_q        <= '0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_cnt_q    <= ch_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      lead_q      <= lead_d;
      sh_q        <= sh_d;
      data_q      <= data_d;
      dv_q        <= dv_d;
      err_q       <= err_d;
    end
  end

  // Next-state, packing and alignment logic.
  always_comb begin
    state_d     = state_q;
    ch_cnt_d    = ch_cnt_q;
    frame_cnt_d = frame_cnt_q;
    lead_d      = lead_q;
    sh_d        = sh_q;
    data_d      = data_q;
    dv_d        = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        if (enable && s_valid) begin
          state_d = START;
        end
      end

      START: begin
        lead_d  = '0;
        state_d = PRIME;
      end

      PRIME: begin
        if (lead_q == LW'(LEAD - 1)) begin
          state_d = FILL;
        end else begin
          lead_d = lead_q + LW'(1);
        end
      end

      FILL: begin
        if (s_valid) begin
          sh_d = {sh_q[DW-SW-1:0], s_data};
          // End-of-frame marker must coincide exactly with the last channel.
          if (s_last != ch_last) begin
            err_d = 1'b1;
          end
          if (ch_last) begin
            ch_cnt_d = '0;
            data_d   = {sh_q[DW-SW-1:0], s_data};
            dv_d     = 1'b1;
            if (frame_last) begin
              frame_cnt_d = '0;
              state_d     = WAIT_DONE;
            end else begin
              frame_cnt_d = frame_cnt_q + FCW'(1);
            end
          end else begin
            ch_cnt_d = ch_cnt_q + CW'(1);
          end
        end
      end

      WAIT_DONE: begin
        if (batch_done) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s_ready       = (state_q == FILL);
  assign start_flag    = (state_q == START);
  assign busy          = (state_q != IDLE);
  assign data_in       = data_q;
  assign data_in_valid = dv_q;
  assign align_err     = err_q;

endmodule

// File: tb/tb_sample_frame_packer.sv
// Directed/randomized bench for sample_frame_packer with a sample-queue
// reference model that assembles expected frames channel by channel.
module tb_sample_frame_packer;
  import proc_pkg::*;

  localparam int unsigned CNT   = 4;
  localparam int unsigned CH    = 22;
  localparam int unsigned SW    = 16;
  localparam int unsigned LEAD  = 3;
  localparam int unsigned DW    = CH * SW;
  localparam int unsigned TOTAL = CNT * CH;

  localparam logic [DW-1:0] FRAME0 =
    352'h0000_0001_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_0010_0011_0012_0013_0014_0015;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [SW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          s_last;
  logic          batch_done;
  logic [DW-1:0] data_in;
  logic          data_in_valid;
  logic          start_flag;
  logic          busy;
  logic          align_err;

  int            compares = 0;
  int            mism     = 0;

  logic [DW-1:0] exp_data;
  bit            exp_dv;
  bit            exp_align;
  bit            f0_pend;
  int            dv_seen;
  int            fidx;
  logic [SW-1:0] cur [CH];

  sample_frame_packer #(
    .CNT (CNT),
    .CH  (CH),
    .SW  (SW),
    .LEAD(LEAD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_last       (s_last),
    .batch_done   (batch_done),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .start_flag   (start_flag),
    .busy         (busy),
    .align_err    (align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compares++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel 0 lands in the most significant slot.
  function automatic logic [DW-1:0] build_frame();
    logic [DW-1:0] f;
    f = '0;
    for (int c = 0; c < int'(CH); c++) begin
      f[(int'(CH) - 1 - c) * int'(SW) +: SW] = cur[c];
    end
    return f;
  endfunction

  task automatic observe(input string ph);
    chk({ph, "_dv"}, DW'(data_in_valid), DW'(exp_dv));
    chk({ph, "_data"}, data_in, exp_data);
    chk({ph, "_align"}, DW'(align_err), DW'(exp_align));
    if (exp_dv && f0_pend) begin
      chk("frame0_const", data_in, FRAME0);
      f0_pend = 1'b0;
    end
    if (exp_dv) dv_seen++;
    exp_dv = 1'b0;
  endtask

  task automatic check_all_zero(input string ph);
    exp_data  = '0;
    exp_dv    = 1'b0;
    exp_align = 1'b0;
    observe(ph);
    chk({ph, "_ready"}, DW'(s_ready), DW'(0));
    chk({ph, "_start"}, DW'(start_flag), DW'(0));
    chk({ph, "_busy"}, DW'(busy), DW'(0));
  endtask

  task automatic run_batch(input bit pattern, input int gap, input int err_n,
                           input int rst_at, input bit done_fill, input int hold,
                           input bit restart);
    int n;
    bit v;
    dv_seen = 0;
    fidx    = 0;
    @(negedge clk);
    observe("idle");
    chk("idle_busy", DW'(busy), DW'(0));
    chk("idle_ready", DW'(s_ready), DW'(0));
    enable  = 1'b1;
    s_valid = 1'b1;
    s_last  = 1'b0;
    s_data  = SW'($urandom);
    @(negedge clk);
    observe("start");
    chk("start_flag", DW'(start_flag), DW'(1));
    chk("start_busy", DW'(busy), DW'(1));
    chk("start_ready", DW'(s_ready), DW'(0));
    enable  = 1'($urandom);
    s_valid = 1'($urandom);
    for (int k = 0; k < int'(LEAD); k++) begin
      @(negedge clk);
      observe("prime");
      chk("prime_flag", DW'(start_flag), DW'(0));
      chk("prime_ready", DW'(s_ready), DW'(0));
      chk("prime_busy", DW'(busy), DW'(1));
    end
    n = 0;
    while (n < int'(TOTAL)) begin
      @(negedge clk);
      observe("fill");
      chk("fill_ready", DW'(s_ready), DW'(1));
      chk("fill_flag", DW'(start_flag), DW'(0));
      if (n == rst_at) begin
        rst_n      = 1'b0;
        s_valid    = 1'b1;
        batch_done = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        rst_n   = 1'b1;
        s_valid = 1'b0;
        enable  = 1'b0;
        return;
      end
      v          = ($urandom_range(99) >= gap);
      s_valid    = v;
      batch_done = done_fill && ($urandom_range(7) == 0);
      s_data     = pattern ? SW'(n) : SW'($urandom);
      s_last     = v && (((n % int'(CH)) == int'(CH) - 1) != (n == err_n));
      if (v) begin
        cur[n % int'(CH)] = s_data;
        if (s_last != ((n % int'(CH)) == int'(CH) - 1)) exp_align = 1'b1;
        if ((n % int'(CH)) == int'(CH) - 1) begin
          exp_dv   = 1'b1;
          exp_data = build_frame();
          if (pattern && fidx == 0) f0_pend = 1'b1;
          fidx++;
        end
        n++;
      end
    end
    @(negedge clk);
    observe("last");
    chk("last_ready", DW'(s_ready), DW'(0));
    chk("last_busy", DW'(busy), DW'(1));
    chk("dv_count", DW'(dv_seen), DW'(CNT));
    s_valid    = 1'b1;
    batch_done = 1'b0;
    enable     = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      observe("wait");
      chk("wait_ready", DW'(s_ready), DW'(0));
      chk("wait_busy", DW'(busy), DW'(1));
      chk("wait_flag", DW'(start_flag), DW'(0));
      s_data = SW'($urandom);
      s_last = 1'($urandom);
    end
    batch_done = 1'b1;
    enable     = restart;
    s_valid    = restart;
    @(negedge clk);
    observe("done");
    chk("done_busy", DW'(busy), DW'(0));
    chk("done_flag", DW'(start_flag), DW'(0));
    chk("done_ready", DW'(s_ready), DW'(0));
    batch_done = 1'b0;
    if (restart) begin
      @(negedge clk);
      observe("restart");
      chk("restart_flag", DW'(start_flag), DW'(1));
      chk("restart_busy", DW'(busy), DW'(1));
      rst_n = 1'b0;
      @(negedge clk);
      check_all_zero("rst2");
      rst_n   = 1'b1;
      enable  = 1'b0;
      s_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    batch_done = 1'b0;
    exp_data   = '0;
    exp_dv     = 1'b0;
    exp_align  = 1'b0;
    f0_pend    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    run_batch(1'b1, 0, -1, -1, 1'b0, 50, 1'b0);
    run_batch(1'b1, 30, -1, -1, 1'b1, 3, 1'b1);
    run_batch(1'b0, 30, 1 * 22 + 10, -1, 1'b0, 4, 1'b0);
    @(negedge clk);
    chk("align_sticky", DW'(align_err), DW'(1));
    run_batch(1'b1, 0, -1, 2 * 22 + 7, 1'b0, 0, 1'b0);
    run_batch(1'b1, 0, -1, -1, 1'b0, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mism);
    $finish;
  end

endmodule
